// File: rtl/config_chain_loader.sv
// Serial loader for a daisy-chained string of switch-cell config registers.
// Takes host words in, shifts them LSB-first into the chain head, and
// returns the old chain contents from the tail as readback words.
//
// Ports:
//   config_clk, config_reset   clock, async active-low reset
//   start, abort               begin a pass / cancel the current pass
//   busy, done                 status; done pulses once per completed pass
//   wr_data/valid/ready        host bitstream words (valid/ready)
//   rd_data/valid/ready        readback words (valid/ready)
//   chain_en, chain_in         shift enable and serial data to chain head
//   chain_out                  serial data from chain tail
//   bits_left                  bits still to shift in this pass
module config_chain_loader #(
    parameter  int unsigned WORD_W    = 32,
    parameter  int unsigned CHAIN_LEN = 96,
    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              config_clk,
    input  logic              config_reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              chain_en,
    output logic              chain_in,
    input  logic              chain_out,
    output logic [CNT_W-1:0]  bits_left
);

    localparam int unsigned WB_W  = $clog2(WORD_W + 1);
    localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_RDBK,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  sreg_q, sreg_d;
    logic [WORD_W-1:0]  cap_q, cap_d;
    logic [CNT_W-1:0]   bits_q, bits_d;
    logic [WB_W-1:0]    wb_q, wb_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    always_ff @(posedge config_clk or negedge config_reset) begin
        if (!config_reset) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cap_q   <= '0;
            bits_q  <= '0;
            wb_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cap_q   <= cap_d;
            bits_q  <= bits_d;
            wb_q    <= wb_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cap_d   = cap_q;
        bits_d  = bits_q;
        wb_d    = wb_q;
        idx_d   = idx_q;
        if (abort && (state_q != S_IDLE)) begin
            // abort outranks every handshake in the same cycle
            state_d = S_IDLE;
            bits_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d = S_FETCH;
                        bits_d  = CNT_W'(CHAIN_LEN);
                    end
                end
                S_FETCH: begin
                    if (wr_valid) begin
                        sreg_d  = wr_data;
                        cap_d   = '0;
                        idx_d   = '0;
                        state_d = S_SHIFT;
                        // last word of a pass may be partial
                        if (32'(bits_q) >= WORD_W) begin
                            wb_d = WB_W'(WORD_W);
                        end else begin
                            wb_d = WB_W'(bits_q);
                        end
                    end
                end
                S_SHIFT: begin
                    // tail bit is captured on the same edge the chain shifts
                    cap_d[idx_q] = chain_out;
                    sreg_d       = sreg_q >> 1;
                    bits_d       = bits_q - CNT_W'(1);
                    idx_d        = idx_q + IDX_W'(1);
                    if (WB_W'(idx_q) == wb_q - WB_W'(1)) begin
                        state_d = S_RDBK;
                    end
                end
                S_RDBK: begin
                    if (rd_ready) begin
                        state_d = (bits_q == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign wr_ready  = (state_q == S_FETCH);
    assign rd_valid  = (state_q == S_RDBK);
    assign chain_en  = (state_q == S_SHIFT);
    assign chain_in  = (state_q == S_SHIFT) & sreg_q[0];
    assign rd_data   = cap_q;
    assign bits_left = bits_q;

endmodule
